// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icodes, status codes and the D-register bubble value.
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] FNONE   = 4'h0;
    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_t;

    typedef struct packed {
        stat_t       stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{SAOK, INOP, FNONE, RNONE, RNONE, 64'h0, 64'h0};
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: redirect/control inputs, instruction memory link and D-register outputs of the fetch stage.
interface fetch_stage_if;
    logic        F_stall;
    logic        D_stall;
    logic        D_bubble;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [79:0] imem_bytes;
    logic        imem_error;
    logic [63:0] f_pc;
    logic [63:0] F_predPC;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    modport master (
        input  F_stall, D_stall, D_bubble, M_icode, M_Cnd, M_valA, W_icode, W_valM,
               imem_bytes, imem_error,
        output f_pc, F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );

    modport slave (
        output F_stall, D_stall, D_bubble, M_icode, M_Cnd, M_valA, W_icode, W_valM,
               imem_bytes, imem_error,
        input  f_pc, F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP
    );
endinterface

// File: rtl/fetch_split.sv
// fetch_split: combinational decode of the 10-byte instruction window into fields and valP.
module fetch_split
    import y86_pkg::*;
(
    input  logic [63:0] f_pc,
    input  logic [79:0] imem_bytes,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic        need_regids,
    output logic        need_valc
);
    assign icode       = imem_bytes[7:4];
    assign ifun        = imem_bytes[3:0];
    assign need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
    assign need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};
    assign ra          = need_regids ? imem_bytes[15:12] : RNONE;
    assign rb          = need_regids ? imem_bytes[11:8] : RNONE;
    // Bytes are little-endian, so the constant word is a straight slice of the window.
    assign valc        = !need_valc ? 64'h0 : need_regids ? imem_bytes[79:16] : imem_bytes[71:8];
    assign valp        = f_pc + 64'd1 + {63'h0, need_regids} + (need_valc ? 64'd8 : 64'd0);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch with PC select, status classification, F predicted-PC and D pipeline registers.
module fetch_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 1024
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);
    logic [63:0] f_pc, valc, valp, pred_pc, pred_q;
    logic [3:0]  s_icode, s_ifun, ra, rb, icode, ifun, len;
    logic        need_regids, need_valc, adr, ins;
    stat_t       stat;
    d_reg_t      d;

    assign f_pc = (bus.M_icode == IJXX && !bus.M_Cnd) ? bus.M_valA :
                  (bus.W_icode == IRET) ? bus.W_valM : pred_q;

    fetch_split u_split (
        .f_pc        (f_pc),
        .imem_bytes  (bus.imem_bytes),
        .icode       (s_icode),
        .ifun        (s_ifun),
        .ra          (ra),
        .rb          (rb),
        .valc        (valc),
        .valp        (valp),
        .need_regids (need_regids),
        .need_valc   (need_valc)
    );

    // 65-bit compare keeps a PC near 2^64 from wrapping past the bound.
    assign len  = 4'd1 + {3'h0, need_regids} + (need_valc ? 4'd8 : 4'd0);
    assign adr  = bus.imem_error || ({1'b0, f_pc} + 65'(len) > 65'(IMEM_BYTES));
    assign ins  = s_icode > IPOPQ;
    assign stat = adr ? SADR : ins ? SINS : (s_icode == IHALT) ? SHLT : SAOK;
    assign icode = adr ? INOP : s_icode;
    assign ifun  = adr ? FNONE : s_ifun;
    assign pred_pc = (icode == IJXX || icode == ICALL) ? valc : (stat != SAOK) ? f_pc : valp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pred_q <= RESET_PC;
        else if (!bus.F_stall) pred_q <= pred_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d <= D_BUBBLE;
        else if (!bus.D_stall) d <= bus.D_bubble ? D_BUBBLE : '{stat, icode, ifun, ra, rb, valc, valp};
    end

    assign bus.f_pc     = f_pc;
    assign bus.F_predPC = pred_q;
    assign bus.D_stat   = d.stat;
    assign bus.D_icode  = d.icode;
    assign bus.D_ifun   = d.ifun;
    assign bus.D_rA     = d.ra;
    assign bus.D_rB     = d.rb;
    assign bus.D_valC   = d.valc;
    assign bus.D_valP   = d.valp;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage reset, field split, redirects, stall/bubble and status.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.F_stall = 0; bus.D_stall = 0; bus.D_bubble = 0;
        bus.M_icode = 0; bus.M_Cnd = 1; bus.M_valA = 0;
        bus.W_icode = 0; bus.W_valM = 0;
        bus.imem_bytes = 80'h10; bus.imem_error = 0;

        #2 rst_n = 0;
        #1;
        chk("rst_predpc", bus.F_predPC, 64'h0);
        chk("rst_icode", bus.D_icode, 64'h1);
        chk("rst_stat", bus.D_stat, 64'h1);
        chk("rst_ra", bus.D_rA, 64'hF);
        chk("rst_rb", bus.D_rB, 64'hF);
        chk("rst_valp", bus.D_valP, 64'h0);
        tick();
        tick();
        rst_n = 1;

        // irmovq $0x1122334455667788, %rbx at pc 0
        bus.imem_bytes = 80'h1122334455667788F330;
        chk("fpc_reset", bus.f_pc, 64'h0);
        tick();
        chk("irm_icode", bus.D_icode, 64'h3);
        chk("irm_ifun", bus.D_ifun, 64'h0);
        chk("irm_ra", bus.D_rA, 64'hF);
        chk("irm_rb", bus.D_rB, 64'h3);
        chk("irm_valc", bus.D_valC, 64'h1122334455667788);
        chk("irm_valp", bus.D_valP, 64'd10);
        chk("irm_stat", bus.D_stat, 64'h1);
        chk("irm_pred", bus.F_predPC, 64'd10);

        // Redirect priority, combinational only
        bus.M_icode = 4'h7; bus.M_Cnd = 0; bus.M_valA = 64'h40;
        #1 chk("redir_mis", bus.f_pc, 64'h40);
        bus.W_icode = 4'h9; bus.W_valM = 64'h100;
        #1 chk("redir_both", bus.f_pc, 64'h40);
        bus.M_icode = 4'h0;
        #1 chk("redir_ret", bus.f_pc, 64'h100);
        bus.M_icode = 4'h7; bus.M_Cnd = 1;
        #1 chk("redir_taken", bus.f_pc, 64'h100);
        bus.M_icode = 0; bus.W_icode = 0;
        #1 chk("redir_none", bus.f_pc, 64'd10);

        // call 0x200 at pc 10
        bus.imem_bytes = 80'h00000000000000020080;
        tick();
        chk("call_icode", bus.D_icode, 64'h8);
        chk("call_valc", bus.D_valC, 64'h200);
        chk("call_valp", bus.D_valP, 64'd19);
        chk("call_ra", bus.D_rA, 64'hF);
        chk("call_pred", bus.F_predPC, 64'h200);

        // Stall both registers for two cycles
        bus.imem_bytes = 80'h1260;
        bus.F_stall = 1; bus.D_stall = 1;
        tick();
        tick();
        chk("stall_pred", bus.F_predPC, 64'h200);
        chk("stall_icode", bus.D_icode, 64'h8);
        chk("stall_valp", bus.D_valP, 64'd19);

        // Bubble while fetching addq at 0x200
        bus.F_stall = 0; bus.D_stall = 0; bus.D_bubble = 1;
        tick();
        chk("bub_icode", bus.D_icode, 64'h1);
        chk("bub_ra", bus.D_rA, 64'hF);
        chk("bub_valp", bus.D_valP, 64'h0);
        chk("bub_pred", bus.F_predPC, 64'h202);

        // rrmovq %rsp, %rbp at 0x202
        bus.D_bubble = 0;
        bus.imem_bytes = 80'h4520;
        tick();
        chk("rr_icode", bus.D_icode, 64'h2);
        chk("rr_ra", bus.D_rA, 64'h4);
        chk("rr_rb", bus.D_rB, 64'h5);
        chk("rr_valp", bus.D_valP, 64'h204);

        // Stall dominates bubble
        bus.F_stall = 1; bus.D_stall = 1; bus.D_bubble = 1;
        tick();
        chk("sb_icode", bus.D_icode, 64'h2);
        chk("sb_ra", bus.D_rA, 64'h4);
        chk("sb_pred", bus.F_predPC, 64'h204);

        // Invalid instruction 0xC0 at 0x204
        bus.F_stall = 0; bus.D_stall = 0; bus.D_bubble = 0;
        bus.imem_bytes = 80'hC0;
        tick();
        chk("ins_stat", bus.D_stat, 64'h4);
        chk("ins_icode", bus.D_icode, 64'hC);
        chk("ins_pred", bus.F_predPC, 64'h204);

        // jmp 0x3FB, then irmovq overruns the end of memory
        bus.imem_bytes = 80'h000000000003FB70;
        tick();
        chk("jmp_icode", bus.D_icode, 64'h7);
        chk("jmp_valp", bus.D_valP, 64'h20D);
        chk("jmp_pred", bus.F_predPC, 64'h3FB);
        bus.imem_bytes = 80'h1122334455667788F330;
        tick();
        chk("adr_stat", bus.D_stat, 64'h3);
        chk("adr_icode", bus.D_icode, 64'h1);
        chk("adr_ifun", bus.D_ifun, 64'h0);
        chk("adr_pred", bus.F_predPC, 64'h3FB);

        // nop ending exactly at IMEM_BYTES is still legal
        bus.M_icode = 4'h7; bus.M_Cnd = 0; bus.M_valA = 64'h3FF;
        bus.imem_bytes = 80'h10;
        tick();
        chk("edge_stat", bus.D_stat, 64'h1);
        chk("edge_pred", bus.F_predPC, 64'h400);

        // halt at 0x80 self-loops
        bus.M_valA = 64'h80;
        bus.imem_bytes = 80'h00;
        tick();
        chk("hlt_stat", bus.D_stat, 64'h2);
        chk("hlt_icode", bus.D_icode, 64'h0);
        chk("hlt_pred", bus.F_predPC, 64'h80);

        // Memory error on an otherwise valid nop
        bus.M_icode = 0;
        bus.imem_bytes = 80'h10;
        bus.imem_error = 1;
        tick();
        chk("merr_stat", bus.D_stat, 64'h3);
        chk("merr_icode", bus.D_icode, 64'h1);
        chk("merr_pred", bus.F_predPC, 64'h80);

        // Asynchronous reset mid-cycle
        bus.imem_error = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_pred", bus.F_predPC, 64'h0);
        chk("arst_stat", bus.D_stat, 64'h1);
        chk("arst_icode", bus.D_icode, 64'h1);
        chk("arst_rb", bus.D_rB, 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
